// File: rtl/q_ram_seq_ctrl_if.sv
// q_ram_seq_ctrl_if: handshake and RAM-side bundle for the quad-RAM sequencer.
// slave modport = controller, master modport = host/datapath side.
// Optional feature macro: Q_CTRL_STALL_CNT_EN adds the 16-bit stall_cnt signal.
interface q_ram_seq_ctrl_if #(
    parameter int WORD_LEN  = 16,
    parameter int ADDR_BITS = 2
);
    logic                 start;
    logic                 in_valid;
    logic                 in_ready;
    logic [WORD_LEN-1:0]  in_m1;
    logic [WORD_LEN-1:0]  in_m2;
    logic                 we;
    logic [WORD_LEN-1:0]  data_m1;
    logic [WORD_LEN-1:0]  data_m2;
    logic [ADDR_BITS-1:0] Dir_M1;
    logic [ADDR_BITS-1:0] Dir_M2;
    logic                 pair_valid;
    logic                 pair_ready;
    logic [ADDR_BITS-1:0] pair_i;
    logic [ADDR_BITS-1:0] pair_j;
    logic                 busy;
    logic                 done;
`ifdef Q_CTRL_STALL_CNT_EN
    logic [15:0]          stall_cnt;
`endif

    modport slave (
`ifdef Q_CTRL_STALL_CNT_EN
        output stall_cnt,
`endif
        input  start, in_valid, in_m1, in_m2, pair_ready,
        output in_ready, we, data_m1, data_m2, Dir_M1, Dir_M2,
        output pair_valid, pair_i, pair_j, busy, done
    );

    modport master (
`ifdef Q_CTRL_STALL_CNT_EN
        input  stall_cnt,
`endif
        output start, in_valid, in_m1, in_m2, pair_ready,
        input  in_ready, we, data_m1, data_m2, Dir_M1, Dir_M2,
        input  pair_valid, pair_i, pair_j, busy, done
    );
endinterface

// File: rtl/q_ram_seq_ctrl.sv
// q_ram_seq_ctrl: load/read sequencer for the quad-RAM matrix store.
// LOAD writes MATRIX_DIM word pairs into consecutive rows; the read phase then
// walks every (M1 row, M2 row) combination, three cycles per pair minimum.
// Optional feature macro: Q_CTRL_STALL_CNT_EN (saturating RD_HOLD stall counter).
module q_ram_seq_ctrl #(
    parameter int WORD_LEN   = 16,
    parameter int MATRIX_DIM = 4,
    parameter int ADDR_BITS  = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    q_ram_seq_ctrl_if.slave  bus
);

    localparam logic [ADDR_BITS-1:0] LAST = ADDR_BITS'(MATRIX_DIM - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RD_ISSUE,
        S_RD_WAIT,
        S_RD_HOLD,
        S_FIN
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [ADDR_BITS-1:0] r_k, r_i, r_j;
    logic [ADDR_BITS-1:0] w_k_nxt, w_i_nxt, w_j_nxt;

    logic                 w_in_ready;
    logic                 w_we;
    logic [WORD_LEN-1:0]  w_data_m1;
    logic [WORD_LEN-1:0]  w_data_m2;
    logic [ADDR_BITS-1:0] w_dir_m1;
    logic [ADDR_BITS-1:0] w_dir_m2;
    logic                 w_pair_valid;
    logic [ADDR_BITS-1:0] w_pair_i;
    logic [ADDR_BITS-1:0] w_pair_j;
    logic                 w_done;

    // State and row counters; async reset returns straight to IDLE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_k     <= '0;
            r_i     <= '0;
            r_j     <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_k     <= w_k_nxt;
            r_i     <= w_i_nxt;
            r_j     <= w_j_nxt;
        end
    end

    // Next-state, counter updates and all outputs decoded from the current state
    always_comb begin
        w_state_nxt  = r_state;
        w_k_nxt      = r_k;
        w_i_nxt      = r_i;
        w_j_nxt      = r_j;
        w_in_ready   = 1'b0;
        w_we         = 1'b0;
        w_data_m1    = '0;
        w_data_m2    = '0;
        w_dir_m1     = '0;
        w_dir_m2     = '0;
        w_pair_valid = 1'b0;
        w_pair_i     = '0;
        w_pair_j     = '0;
        w_done       = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_state_nxt = S_LOAD;
                    w_k_nxt     = '0;
                end
            end

            S_LOAD: begin
                w_in_ready = 1'b1;
                w_dir_m1   = r_k;
                w_dir_m2   = r_k;
                if (bus.in_valid) begin
                    w_we      = 1'b1;
                    w_data_m1 = bus.in_m1;
                    w_data_m2 = bus.in_m2;
                    if (r_k >= LAST) begin
                        w_state_nxt = S_RD_ISSUE;
                        w_k_nxt     = '0;
                        w_i_nxt     = '0;
                        w_j_nxt     = '0;
                    end else begin
                        w_k_nxt = r_k + ADDR_BITS'(1);
                    end
                end
            end

            S_RD_ISSUE: begin
                w_dir_m1    = r_i;
                w_dir_m2    = r_j;
                w_state_nxt = S_RD_WAIT;
            end

            S_RD_WAIT: begin
                w_dir_m1    = r_i;
                w_dir_m2    = r_j;
                w_state_nxt = S_RD_HOLD;
            end

            S_RD_HOLD: begin
                w_dir_m1     = r_i;
                w_dir_m2     = r_j;
                w_pair_valid = 1'b1;
                w_pair_i     = r_i;
                w_pair_j     = r_j;
                if (bus.pair_ready) begin
                    if (r_j < LAST) begin
                        w_j_nxt     = r_j + ADDR_BITS'(1);
                        w_state_nxt = S_RD_ISSUE;
                    end else begin
                        w_j_nxt = '0;
                        if (r_i < LAST) begin
                            w_i_nxt     = r_i + ADDR_BITS'(1);
                            w_state_nxt = S_RD_ISSUE;
                        end else begin
                            w_i_nxt     = '0;
                            w_state_nxt = S_FIN;
                        end
                    end
                end
            end

            S_FIN: begin
                w_done      = 1'b1;
                w_state_nxt = S_IDLE;
            end

            default: w_state_nxt = S_IDLE;
        endcase
    end

`ifdef Q_CTRL_STALL_CNT_EN
    logic [15:0] r_stall_cnt;

    // Saturating count of RD_HOLD cycles without pair_ready; cleared by an accepted start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (r_state == S_IDLE && bus.start) begin
            r_stall_cnt <= '0;
        end else if (r_state == S_RD_HOLD && !bus.pair_ready && r_stall_cnt != '1) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign bus.stall_cnt = r_stall_cnt;
`endif

    assign bus.in_ready   = w_in_ready;
    assign bus.we         = w_we;
    assign bus.data_m1    = w_data_m1;
    assign bus.data_m2    = w_data_m2;
    assign bus.Dir_M1     = w_dir_m1;
    assign bus.Dir_M2     = w_dir_m2;
    assign bus.pair_valid = w_pair_valid;
    assign bus.pair_i     = w_pair_i;
    assign bus.pair_j     = w_pair_j;
    assign bus.busy       = (r_state != S_IDLE);
    assign bus.done       = w_done;

endmodule

// File: tb/tb_q_ram_seq_ctrl.sv
// tb_q_ram_seq_ctrl: directed run sequence with randomized data, gaps and
// backpressure, checked against expectations computed from the run rules.
// Optional feature macro: Q_CTRL_STALL_CNT_EN enables stall_cnt checks.
module tb_q_ram_seq_ctrl;
    localparam int WL = 16;
    localparam int N  = 4;
    localparam int AB = 2;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_fail;
    int   st_exp;
    bit   aborted;

    q_ram_seq_ctrl_if #(.WORD_LEN(WL), .ADDR_BITS(AB)) bus ();

    q_ram_seq_ctrl #(.WORD_LEN(WL), .MATRIX_DIM(N), .ADDR_BITS(AB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail + 1);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic abort_run(input string tag);
        $display("FAIL %s: bound expired", tag);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail + 1);
        $fatal(1, "bound expired");
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ctl"}, 32'({bus.we, bus.in_ready, bus.busy, bus.done, bus.pair_valid}), 32'd0);
        chk({tag, "_adr"}, 32'({bus.Dir_M1, bus.Dir_M2, bus.pair_i, bus.pair_j}), 32'd0);
        chk({tag, "_dat"}, 32'({bus.data_m1, bus.data_m2}), 32'd0);
`ifdef Q_CTRL_STALL_CNT_EN
        chk({tag, "_stall"}, 32'(bus.stall_cnt), 32'd0);
`endif
    endtask

    // Entered and left just after a falling edge
    task automatic idle_cycles(input int n);
        for (int c = 0; c < n; c++) begin
            bus.start      = 1'b0;
            bus.in_valid   = 1'($urandom);
            bus.pair_ready = 1'($urandom);
            #1;
            chk("idle_busy", 32'(bus.busy), 32'd0);
            chk("idle_io", 32'({bus.in_ready, bus.we, bus.done, bus.pair_valid}), 32'd0);
            @(negedge clk);
        end
    endtask

    task automatic do_start();
        bus.start    = 1'b1;
        bus.in_valid = 1'($urandom);
        #1;
        chk("start_idle", 32'({bus.busy, bus.in_ready, bus.we}), 32'd0);
        @(negedge clk);
        bus.start = 1'b0;
        st_exp    = 0;
    endtask

    // mode 0: back-to-back directed pairs; 1: valid alternating; 2: random valid + stray start
    task automatic load_phase(input int mode);
        int acc;
        int cyc;
        logic v;
        logic [WL-1:0] m1, m2;
        acc = 0;
        cyc = 0;
        while (acc < N) begin
            v  = (mode == 0) ? 1'b1 : (mode == 1) ? ((cyc % 2) == 0) : 1'($urandom);
            m1 = (mode == 0) ? WL'(acc + 1) : WL'($urandom);
            m2 = (mode == 0) ? WL'((acc + 1) * 10) : WL'($urandom);
            bus.start    = (mode == 2 && cyc == 1);
            bus.in_valid = v;
            bus.in_m1    = m1;
            bus.in_m2    = m2;
            #1;
            chk("ld_ready", 32'({bus.in_ready, bus.busy}), 32'd3);
            chk("ld_we", 32'(bus.we), 32'(v));
            chk("ld_dir_m1", 32'(bus.Dir_M1), 32'(acc));
            chk("ld_dir_m2", 32'(bus.Dir_M2), 32'(acc));
            if (v) begin
                chk("ld_data_m1", 32'(bus.data_m1), 32'(m1));
                chk("ld_data_m2", 32'(bus.data_m2), 32'(m2));
            end
            @(negedge clk);
            if (v) acc++;
            cyc++;
            if (cyc > 64) abort_run("ld_timeout");
        end
        bus.start    = 1'b0;
        bus.in_valid = 1'b1;
        #1;
        chk("ld_ready_fall", 32'({bus.in_ready, bus.we, bus.busy}), 32'd1);
    endtask

    // mode 0: no stalls; 1: 7 stalls on pair (1,2); 2: random stalls
    task automatic read_phase(input int mode, input int abort_idx, output bit ab);
        int w;
        int s;
        int ei;
        int ej;
        ab = 1'b0;
        for (int p = 0; p < N * N; p++) begin
            ei = p / N;
            ej = p % N;
            w  = 0;
            forever begin
                bus.pair_ready = 1'($urandom);
                bus.in_valid   = 1'($urandom);
                bus.start      = 1'($urandom);
                #1;
                if (bus.pair_valid) break;
                chk("rd_wait_io", 32'({bus.we, bus.in_ready, bus.done, bus.busy}), 32'd1);
                chk("rd_wait_dir", 32'({bus.Dir_M1, bus.Dir_M2}), 32'({AB'(ei), AB'(ej)}));
                @(negedge clk);
                w++;
                if (w > 8) abort_run("rd_timeout");
            end
            chk("rd_gap", 32'(w), 32'd2);
            s = (mode == 1) ? ((ei == 1 && ej == 2) ? 7 : 0)
              : (mode == 2) ? int'($urandom_range(0, 3)) : 0;
            if (p == abort_idx) s = 2;
            for (int h = 0; h <= s; h++) begin
                bus.pair_ready = (h == s);
                bus.start      = 1'($urandom);
                #1;
                chk("rd_pair_valid", 32'(bus.pair_valid), 32'd1);
                chk("rd_pair_ij", 32'({bus.pair_i, bus.pair_j}), 32'({AB'(ei), AB'(ej)}));
                chk("rd_hold_dir", 32'({bus.Dir_M1, bus.Dir_M2}), 32'({AB'(ei), AB'(ej)}));
                chk("rd_hold_io", 32'({bus.we, bus.done, bus.busy}), 32'd1);
                if (p == abort_idx && h == 1) begin
                    rst_n = 1'b0;
                    #1;
                    chk_zero("abort");
                    ab = 1'b1;
                    return;
                end
                @(negedge clk);
                if (h < s) st_exp++;
            end
        end
        bus.start      = 1'b0;
        bus.pair_ready = 1'b1;
        #1;
        chk("fin_done", 32'({bus.done, bus.busy, bus.pair_valid}), 32'd6);
`ifdef Q_CTRL_STALL_CNT_EN
        chk("fin_stall_cnt", 32'(bus.stall_cnt), 32'(st_exp));
`endif
        @(negedge clk);
        #1;
        chk("post_fin", 32'({bus.done, bus.busy}), 32'd0);
`ifdef Q_CTRL_STALL_CNT_EN
        chk("post_fin_stall", 32'(bus.stall_cnt), 32'(st_exp));
`endif
    endtask

    initial begin
        n_chk          = 0;
        n_fail         = 0;
        st_exp         = 0;
        rst_n          = 1'b0;
        bus.start      = 1'b0;
        bus.in_valid   = 1'b1;
        bus.in_m1      = '1;
        bus.in_m2      = '1;
        bus.pair_ready = 1'b1;
        #1;
        chk_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        idle_cycles(5);

        // Run 1: directed back-to-back load, free-running read
        do_start();
        load_phase(0);
        read_phase(0, -1, aborted);
        @(negedge clk);
        idle_cycles(2);

        // Run 2: gapped load, 7-cycle stall on pair (1,2)
        do_start();
        load_phase(1);
        read_phase(1, -1, aborted);
        @(negedge clk);
        idle_cycles(1);

        // Run 3: random load with stray start, reset during pair (2,0)
        do_start();
        load_phase(2);
        read_phase(2, 2 * N, aborted);
        chk("abort_taken", 32'(aborted), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk_zero("after_abort");
        @(negedge clk);
        idle_cycles(2);

        // Run 4: full restart with random backpressure
        do_start();
        load_phase(2);
        read_phase(2, -1, aborted);
        @(negedge clk);
        idle_cycles(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/q_ram_seq_ctrl.md
Name: q_ram_seq_ctrl

Overview:
- Sequencer for the quad-RAM matrix store (M1/M2, real/imag banks).
- Run phases:
  - Load: accepts a valid/ready stream of word pairs and writes them into consecutive RAM rows.
  - Read: walks every (row of M1, row of M2) combination and presents each pair to the downstream multiply-accumulate with a valid/ready handshake.
- Sits between the host/input stream and the RAM bank on one side, and the matmul datapath on the other.
- M2 is stored transposed by the producer.

Parameters:
- WORD_LEN, 16, element width; matches the RAM data port.
- MATRIX_DIM, 4, matrix order N. The RAM holds N rows per bank.
- ADDR_BITS, 2, RAM row-address width. Requires 2**ADDR_BITS >= MATRIX_DIM.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a run; ignored unless IDLE.
- in_valid  in  1  input pair valid.
- in_ready  out  1  controller accepts input pair.
- in_m1  in  WORD_LEN  M1 element.
- in_m2  in  WORD_LEN  M2 element.
- we  out  1  RAM write enable, shared by all four banks.
- data_m1  out  WORD_LEN  write data, M1 banks.
- data_m2  out  WORD_LEN  write data, M2 banks.
- Dir_M1  out  ADDR_BITS  M1 bank row address.
- Dir_M2  out  ADDR_BITS  M2 bank row address.
- pair_valid  out  1  RAM outputs hold row pair (pair_i, pair_j).
- pair_ready  in  1  downstream consumes the pair.
- pair_i  out  ADDR_BITS  current M1 row index.
- pair_j  out  ADDR_BITS  current M2 row index.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse at the end of the run.

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE; all outputs 0.
  - Address and row counters are 0.
- States: IDLE, LOAD, RD_ISSUE, RD_WAIT, RD_HOLD, FIN.
- IDLE:
  - in_ready=0, we=0.
  - start=1 -> LOAD with load counter k=0.
- LOAD:
  - in_ready=1.
  - Each cycle with in_valid=1, drive combinationally:
    - we=1
    - data_m1=in_m1, data_m2=in_m2
    - Dir_M1=Dir_M2=k
  - k increments on each accepted pair.
  - The accept with k==MATRIX_DIM-1 leads to RD_ISSUE with i=j=0. in_ready falls the next cycle.
  - in_valid=0 gives we=0; address holds.
- RD_ISSUE:
  - we=0, Dir_M1=i, Dir_M2=j -> RD_WAIT.
  - Addresses stay stable through RD_HOLD, covering the 1-cycle RAM read latency.
- RD_WAIT: -> RD_HOLD.
- RD_HOLD:
  - pair_valid=1, pair_i=i, pair_j=j; values held until pair_ready=1.
  - On pair_ready=1:
    - If j<MATRIX_DIM-1: j++, go to RD_ISSUE.
    - Else j=0. If i<MATRIX_DIM-1: i++, go to RD_ISSUE.
    - Else go to FIN.
  - pair_valid drops the cycle after the handshake.
- FIN: done=1 for exactly one cycle -> IDLE.
- busy = (state != IDLE).
- Throughput: 3 cycles per pair minimum. One run = MATRIX_DIM^2 pairs.
- Counters are ADDR_BITS wide and compare against MATRIX_DIM-1. They never wrap past MATRIX_DIM-1.
- start while busy: ignored, no effect on counters.
- in_valid outside LOAD: ignored, in_ready=0, we=0.
- pair_ready outside RD_HOLD: ignored.
- rst_n asserted mid-run: immediate return to IDLE.
  - we deasserts asynchronously.
  - RAM contents are undefined for that run.
- MATRIX_DIM=1: a single load accept, then a single pair, then FIN.

Optional Feature:
- Macro: Q_CTRL_STALL_CNT_EN.
- When defined, add the following:
  - Output port stall_cnt, 16 bits, counting cycles in RD_HOLD with pair_ready=0.
  - Cleared on reset and on start accepted in IDLE.
  - Saturates at 16'hFFFF.
  - Holds its value after FIN until the next start.
- When undefined: the port and the counter are absent; all other behaviour is identical.

Test Plan:
- Reset, MATRIX_DIM=4: with rst_n=0, all outputs 0. Release rst_n, hold 5 cycles without start -> busy=0, in_ready=0.
- Load:
  - Stimulus: start, then 4 back-to-back pairs (1,10), (2,20), (3,30), (4,40).
  - Expect we=1 with Dir=0..3 and matching data on each cycle.
  - Expect in_ready=0 on the cycle after the 4th accept.
- Load with gaps: in_valid toggling 1,0,1,0,... -> we only on valid cycles, addresses 0..3 with no skips.
- Read order, pair_ready tied 1:
  - Expect 16 pair_valid pulses, (i,j) = (0,0),(0,1),...,(3,3), spaced 3 cycles apart.
  - Expect done a single cycle after the last handshake; busy falls with it.
- Backpressure:
  - pair_ready=0 for 7 cycles on pair (1,2) -> pair_valid, pair_i=1, pair_j=2 and the addresses hold.
  - With Q_CTRL_STALL_CNT_EN defined, stall_cnt=7 at done.
- Abort and restart:
  - Assert rst_n=0 during RD_HOLD of pair (2,0) -> outputs 0 immediately.
  - A new start then reloads from k=0 and reads from (0,0).
  - A start pulsed during LOAD is ignored (k unchanged).
